// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned INSN_BYTES       = 4;
   localparam logic [1:0]  ALIGN_MASK       = 2'b11;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0010;

endpackage : fetch_pkg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word read per cycle into a
// single valid/ready output slot, and handles redirects and misaligned faults.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter int               DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              halt,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_ins,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic [31:0]       fetch_cnt
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_ins_q, out_ins_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   logic space;
   logic load;

   // Issue decision: fetch only in RUN, with room in the slot, and no redirect pending.
   always_comb begin
      space = !out_valid_q || out_ready;
      load  = (state_q == RUN) && space && !halt && !br_taken;
   end

   // Next-state, next-PC and slot update; a redirect takes priority over a load.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      out_valid_d  = out_valid_q;
      out_ins_d    = out_ins_q;
      out_pc_d     = out_pc_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      fetch_cnt_d  = fetch_cnt_q;
      case (state_q)
         BOOT: begin
            // Redirects during the boot cycle are deliberately ignored.
            state_d = RUN;
         end
         RUN, FAULT: begin
            if (br_taken) begin
               out_valid_d = 1'b0;
               if ((br_target[1:0] & ALIGN_MASK) == 2'b00) begin
                  pc_d    = br_target;
                  state_d = RUN;
                  fault_d = 1'b0;
               end else begin
                  state_d      = FAULT;
                  fault_d      = 1'b1;
                  fault_addr_d = br_target;
               end
            end else if (load) begin
               out_ins_d   = mem_rdata;
               out_pc_d    = pc_q;
               out_valid_d = 1'b1;
               pc_d        = pc_q + ADDR_W'(INSN_BYTES);
               fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and datapath registers; reset clears the slot so nothing is replayed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_ins_q    <= '0;
         out_pc_q     <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         out_valid_q  <= out_valid_d;
         out_ins_q    <= out_ins_d;
         out_pc_q     <= out_pc_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   // Memory interface is read-only from this stage.
   always_comb begin
      mem_addr   = pc_q;
      mem_rd     = load;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      out_valid  = out_valid_q;
      out_ins    = out_ins_q;
      out_pc     = out_pc_q;
      fault      = fault_q;
      fault_addr = fault_addr_q;
      fetch_cnt  = fetch_cnt_q;
   end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a small combinational memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        halt;
   logic        br_taken;
   logic [31:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ins;
   logic [31:0] out_pc;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   fetch_stage #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(32'h0000_0010)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .halt      (halt),
      .br_taken  (br_taken),
      .br_target (br_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ins   (out_ins),
      .out_pc    (out_pc),
      .fault     (fault),
      .fault_addr(fault_addr),
      .fetch_cnt (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Preloaded words; any other address returns its own bitwise complement.
   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'd16:  return 32'h1234_5678;
         32'd20:  return 32'h0000_0000;
         32'd24:  return 32'h89ab_cdef;
         32'd64:  return 32'hdead_beef;
         default: return ~a;
      endcase
   endfunction

   always_comb mem_rdata = memf(mem_addr);

   typedef struct {
      logic        rst_n;
      logic        halt;
      logic        br;
      logic        rdy;
      logic [31:0] tgt;
      logic        e_rd;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_ins;
      logic [31:0] e_opc;
      logic        e_flt;
      logic [31:0] e_fa;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic r, input logic h, input logic b, input logic rdy,
                               input logic [31:0] tgt, input logic erd, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                               input logic ef, input logic [31:0] efa, input logic [31:0] ec);
      vec_t v;
      v.rst_n = r;   v.halt = h;   v.br = b;     v.rdy = rdy;  v.tgt = tgt;
      v.e_rd = erd;  v.e_addr = ea; v.e_vld = ev; v.e_ins = ei; v.e_opc = ep;
      v.e_flt = ef;  v.e_fa = efa; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      //                rst h b r tgt            rd addr          vld ins            opc            flt fa     cnt
      // reset + boot + three loads
      vecs[0]  = mk(0, 0, 0, 1, 32'd0,         0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[1]  = mk(1, 0, 0, 1, 32'd0,         0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[2]  = mk(1, 0, 0, 1, 32'd0,         1, 32'd16,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[3]  = mk(1, 0, 0, 1, 32'd0,         1, 32'd20,       1, 32'h0000_0000, 32'd20,        0, 32'd0,  32'd2);
      vecs[4]  = mk(1, 0, 0, 1, 32'd0,         1, 32'd24,       1, 32'h89ab_cdef, 32'd24,        0, 32'd0,  32'd3);
      // backpressure
      vecs[5]  = mk(0, 0, 0, 1, 32'd0,         0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[6]  = mk(1, 0, 0, 1, 32'd0,         0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[7]  = mk(1, 0, 0, 1, 32'd0,         1, 32'd16,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[8]  = mk(1, 0, 0, 0, 32'd0,         0, 32'd20,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[9]  = mk(1, 0, 0, 0, 32'd0,         0, 32'd20,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[10] = mk(1, 0, 0, 0, 32'd0,         0, 32'd20,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[11] = mk(1, 0, 0, 0, 32'd0,         0, 32'd20,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[12] = mk(1, 0, 0, 1, 32'd0,         1, 32'd20,       1, 32'h0000_0000, 32'd20,        0, 32'd0,  32'd2);
      // aligned redirect flushes slot holding pc 20
      vecs[13] = mk(1, 0, 1, 1, 32'd64,        0, 32'd24,       0, 32'h0,         32'h0,         0, 32'd0,  32'd2);
      vecs[14] = mk(1, 0, 0, 1, 32'd0,         1, 32'd64,       1, 32'hdead_beef, 32'd64,        0, 32'd0,  32'd3);
      vecs[15] = mk(1, 0, 0, 1, 32'd0,         1, 32'd68,       1, 32'hFFFF_FFBB, 32'd68,        0, 32'd0,  32'd4);
      // misaligned redirects, then recovery
      vecs[16] = mk(1, 0, 1, 1, 32'd66,        0, 32'd72,       0, 32'h0,         32'h0,         1, 32'd66, 32'd4);
      vecs[17] = mk(1, 0, 1, 1, 32'd67,        0, 32'd72,       0, 32'h0,         32'h0,         1, 32'd67, 32'd4);
      vecs[18] = mk(1, 0, 0, 1, 32'd0,         0, 32'd72,       0, 32'h0,         32'h0,         1, 32'd67, 32'd4);
      vecs[19] = mk(1, 0, 1, 1, 32'd16,        0, 32'd72,       0, 32'h0,         32'h0,         0, 32'd67, 32'd4);
      vecs[20] = mk(1, 0, 0, 1, 32'd0,         1, 32'd16,       1, 32'h1234_5678, 32'd16,        0, 32'd67, 32'd5);
      // halt for three cycles
      vecs[21] = mk(1, 1, 0, 1, 32'd0,         0, 32'd20,       0, 32'h0,         32'h0,         0, 32'd67, 32'd5);
      vecs[22] = mk(1, 1, 0, 1, 32'd0,         0, 32'd20,       0, 32'h0,         32'h0,         0, 32'd67, 32'd5);
      vecs[23] = mk(1, 1, 0, 1, 32'd0,         0, 32'd20,       0, 32'h0,         32'h0,         0, 32'd67, 32'd5);
      vecs[24] = mk(1, 0, 0, 1, 32'd0,         1, 32'd20,       1, 32'h0000_0000, 32'd20,        0, 32'd67, 32'd6);
      // branch during BOOT ignored, then wrap
      vecs[25] = mk(0, 0, 0, 1, 32'd0,         0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[26] = mk(1, 0, 1, 1, 32'd64,        0, 32'd16,       0, 32'h0,         32'h0,         0, 32'd0,  32'd0);
      vecs[27] = mk(1, 0, 0, 1, 32'd0,         1, 32'd16,       1, 32'h1234_5678, 32'd16,        0, 32'd0,  32'd1);
      vecs[28] = mk(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'd20,       0, 32'h0,         32'h0,         0, 32'd0,  32'd1);
      vecs[29] = mk(1, 0, 0, 1, 32'd0,         1, 32'hFFFF_FFFC, 1, 32'h0000_0003, 32'hFFFF_FFFC, 0, 32'd0,  32'd2);
      vecs[30] = mk(1, 0, 0, 1, 32'd0,         1, 32'd0,        1, 32'hFFFF_FFFF, 32'd0,         0, 32'd0,  32'd3);

      rst_n     = 1'b1;
      halt      = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'd0;
      out_ready = 1'b1;
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         rst_n     = vecs[i].rst_n;
         halt      = vecs[i].halt;
         br_taken  = vecs[i].br;
         br_target = vecs[i].tgt;
         out_ready = vecs[i].rdy;
         #2;
         chk("mem_rd", i, 32'(mem_rd), 32'(vecs[i].e_rd));
         chk("mem_addr", i, mem_addr, vecs[i].e_addr);
         chk("mem_wr", i, 32'(mem_wr), 32'd0);
         @(posedge clk);
         #1;
         chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk("out_ins", i, out_ins, vecs[i].e_ins);
            chk("out_pc", i, out_pc, vecs[i].e_opc);
         end
         chk("fault", i, 32'(fault), 32'(vecs[i].e_flt));
         chk("fault_addr", i, fault_addr, vecs[i].e_fa);
         chk("fetch_cnt", i, fetch_cnt, vecs[i].e_cnt);
      end

      // Mid-cycle asynchronous reset: everything clears before the next edge.
      halt     = 1'b0;
      br_taken = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 0, 32'(out_valid), 32'd0);
      chk("async_ins", 0, out_ins, 32'd0);
      chk("async_pc", 0, out_pc, 32'd0);
      chk("async_cnt", 0, fetch_cnt, 32'd0);
      chk("async_rd", 0, 32'(mem_rd), 32'd0);
      chk("async_addr", 0, mem_addr, 32'd16);
      chk("async_fault", 0, 32'(fault), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      chk("boot_rd", 0, 32'(mem_rd), 32'd0);
      @(posedge clk);
      #1;
      chk("post_boot_rd", 0, 32'(mem_rd), 32'd1);
      chk("post_boot_addr", 0, mem_addr, 32'd16);
      chk("post_boot_valid", 0, 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_stage
